// File: rtl/cheshire_eoc_monitor.sv
// rtl/cheshire_eoc_monitor.sv - polls per-channel scratch words until every enabled channel reports end of computation
module cheshire_eoc_monitor #(
  parameter int unsigned NumChannels   = 4,
  parameter int unsigned AddrWidth     = 64,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned CodeWidth     = 31,
  parameter int unsigned ChanStride    = 4,
  parameter int unsigned PollInterval  = 16,
  parameter int unsigned TimeoutCycles = 0
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             start_i,
  input  logic [NumChannels-1:0]           chan_en_i,
  input  logic [AddrWidth-1:0]             base_addr_i,
  output logic                             rd_req_o,
  output logic [AddrWidth-1:0]             rd_addr_o,
  input  logic                             rd_gnt_i,
  input  logic                             rd_rvalid_i,
  input  logic [DataWidth-1:0]             rd_rdata_i,
  input  logic                             rd_err_i,
  output logic                             busy_o,
  output logic                             eoc_o,
  output logic                             pass_o,
  output logic                             timeout_o,
  output logic                             err_o,
  output logic [NumChannels-1:0]           done_o,
  output logic [NumChannels*CodeWidth-1:0] exit_code_o
);

  localparam int unsigned IdxW = (NumChannels > 1) ? $clog2(NumChannels) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_REQ, S_RESP, S_DONE} state_e;

  state_e                           r_state;
  logic [NumChannels-1:0]           r_en;
  logic [AddrWidth-1:0]             r_base;
  logic [IdxW-1:0]                  r_idx;
  logic [31:0]                      r_ivl;
  logic [31:0]                      r_cyc;
  logic                             r_pend;
  logic [NumChannels-1:0]           r_done;
  logic [NumChannels*CodeWidth-1:0] r_code;
  logic                             r_timeout;
  logic                             r_err;
  logic                             r_eoc;
  logic                             r_pass;

  logic                             w_rsp_ok;
  logic [NumChannels-1:0]           w_done_next;
  logic [NumChannels*CodeWidth-1:0] w_code_next;
  logic                             w_all_done;
  logic [IdxW-1:0]                  w_next_idx;
  logic [IdxW-1:0]                  w_first_idx;
  logic                             w_found;
  int unsigned                      w_c;
  logic [31:0]                      w_cyc_next;
  logic                             w_hit;
  logic                             w_pend;

  // Response recording and round-robin successor, evaluated from the pending response
  always_comb begin
    w_rsp_ok    = (r_state == S_RESP) && rd_rvalid_i && !rd_err_i && rd_rdata_i[0];
    w_done_next = r_done;
    w_code_next = r_code;
    if (w_rsp_ok) begin
      w_done_next[r_idx] = 1'b1;
      w_code_next[r_idx*CodeWidth +: CodeWidth] = rd_rdata_i[CodeWidth:1];
    end
    w_all_done = ((w_done_next & r_en) == r_en);

    w_next_idx = r_idx;
    w_found    = 1'b0;
    w_c        = 0;
    for (int k = 1; k <= int'(NumChannels); k++) begin
      w_c = (int'(r_idx) + k) % NumChannels;
      if (!w_found && r_en[w_c] && !w_done_next[w_c]) begin
        w_next_idx = IdxW'(w_c);
        w_found    = 1'b1;
      end
    end

    w_first_idx = '0;
    for (int k = int'(NumChannels) - 1; k >= 0; k--) begin
      if (chan_en_i[k]) w_first_idx = IdxW'(k);
    end

    w_cyc_next = (r_cyc == 32'hFFFF_FFFF) ? r_cyc : r_cyc + 32'd1;
    w_hit      = (TimeoutCycles != 0) && (w_cyc_next == TimeoutCycles);
    w_pend     = r_pend || w_hit;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_en      <= '0;
      r_base    <= '0;
      r_idx     <= '0;
      r_ivl     <= '0;
      r_cyc     <= '0;
      r_pend    <= 1'b0;
      r_done    <= '0;
      r_code    <= '0;
      r_timeout <= 1'b0;
      r_err     <= 1'b0;
      r_eoc     <= 1'b0;
      r_pass    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            r_en      <= chan_en_i;
            r_base    <= base_addr_i;
            r_done    <= '0;
            r_code    <= '0;
            r_timeout <= 1'b0;
            r_err     <= 1'b0;
            r_cyc     <= '0;
            r_pend    <= 1'b0;
            if (chan_en_i != '0) begin
              r_idx   <= w_first_idx;
              r_ivl   <= PollInterval;
              r_eoc   <= 1'b0;
              r_pass  <= 1'b0;
              r_state <= S_WAIT;
            end else begin
              r_eoc   <= 1'b1;
              r_pass  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_WAIT: begin
          r_cyc  <= w_cyc_next;
          r_pend <= w_pend;
          if (w_pend) begin
            r_timeout <= 1'b1;
            r_eoc     <= 1'b1;
            r_pass    <= 1'b0;
            r_state   <= S_DONE;
          end else if (r_ivl == 32'd0) begin
            r_state <= S_REQ;
          end else begin
            r_ivl <= r_ivl - 32'd1;
          end
        end
        S_REQ: begin
          r_cyc  <= w_cyc_next;
          r_pend <= w_pend;
          if (rd_gnt_i) r_state <= S_RESP;
        end
        S_RESP: begin
          r_cyc  <= w_cyc_next;
          r_pend <= w_pend;
          if (rd_rvalid_i) begin
            r_done <= w_done_next;
            r_code <= w_code_next;
            if (rd_err_i) begin
              r_err     <= 1'b1;
              r_timeout <= w_pend;
              r_eoc     <= 1'b1;
              r_pass    <= 1'b0;
              r_state   <= S_DONE;
            end else if (w_all_done) begin
              // Completion outranks a timeout landing in the same cycle
              r_eoc   <= 1'b1;
              r_pass  <= (w_code_next == '0);
              r_state <= S_DONE;
            end else if (w_pend) begin
              r_timeout <= 1'b1;
              r_eoc     <= 1'b1;
              r_pass    <= 1'b0;
              r_state   <= S_DONE;
            end else begin
              r_idx   <= w_next_idx;
              r_ivl   <= PollInterval;
              r_state <= S_WAIT;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd_req_o    = (r_state == S_REQ);
  assign rd_addr_o   = r_base + AddrWidth'(r_idx) * AddrWidth'(ChanStride);
  assign busy_o      = (r_state == S_WAIT) || (r_state == S_REQ) || (r_state == S_RESP);
  assign eoc_o       = r_eoc;
  assign pass_o      = r_pass;
  assign timeout_o   = r_timeout;
  assign err_o       = r_err;
  assign done_o      = r_done;
  assign exit_code_o = r_code;

endmodule

// File: tb/tb_cheshire_eoc_monitor.sv
// tb/tb_cheshire_eoc_monitor.sv - directed self-checking bench for cheshire_eoc_monitor
module tb_cheshire_eoc_monitor;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         start_i;
  logic [3:0]   chan_en_i;
  logic [63:0]  base_addr_i;
  logic         rd_req_o;
  logic [63:0]  rd_addr_o;
  logic         rd_gnt_i;
  logic         rd_rvalid_i;
  logic [31:0]  rd_rdata_i;
  logic         rd_err_i;
  logic         busy_o;
  logic         eoc_o;
  logic         pass_o;
  logic         timeout_o;
  logic         err_o;
  logic [3:0]   done_o;
  logic [123:0] exit_code_o;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cheshire_eoc_monitor #(
    .NumChannels(4), .AddrWidth(64), .DataWidth(32), .CodeWidth(31),
    .ChanStride(4), .PollInterval(2), .TimeoutCycles(50)
  ) u_dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .chan_en_i(chan_en_i),
    .base_addr_i(base_addr_i), .rd_req_o(rd_req_o), .rd_addr_o(rd_addr_o),
    .rd_gnt_i(rd_gnt_i), .rd_rvalid_i(rd_rvalid_i), .rd_rdata_i(rd_rdata_i),
    .rd_err_i(rd_err_i), .busy_o(busy_o), .eoc_o(eoc_o), .pass_o(pass_o),
    .timeout_o(timeout_o), .err_o(err_o), .done_o(done_o), .exit_code_o(exit_code_o)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_run(input logic [3:0] en, input logic [63:0] base);
    @(negedge clk);
    start_i = 1'b1; chan_en_i = en; base_addr_i = base;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic serve(input string tag, input logic [63:0] addr, input logic [31:0] data,
                       input logic err, input int gdly);
    int n = 0;
    while (rd_req_o !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk({tag, "_req"}, 128'(rd_req_o), 128'(1));
    chk({tag, "_addr"}, 128'(rd_addr_o), 128'(addr));
    for (int d = 0; d < gdly; d++) begin
      @(negedge clk);
      chk({tag, "_hold"}, 128'({rd_req_o, rd_addr_o}), 128'({1'b1, addr}));
    end
    rd_gnt_i = 1'b1;
    @(negedge clk);
    rd_gnt_i = 1'b0;
    chk({tag, "_one_outstanding"}, 128'(rd_req_o), 128'(0));
    rd_rvalid_i = 1'b1; rd_rdata_i = data; rd_err_i = err;
    @(negedge clk);
    rd_rvalid_i = 1'b0; rd_rdata_i = '0; rd_err_i = 1'b0;
  endtask

  task automatic wait_eoc(input string tag);
    int n = 0;
    while (eoc_o !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk({tag, "_eoc"}, 128'(eoc_o), 128'(1));
  endtask

  task automatic quiet(input int cycles, output int reqs);
    reqs = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (rd_req_o !== 1'b0) reqs++;
    end
  endtask

  logic [63:0] a3 [7];
  logic [31:0] d3 [7];
  int          reqs;
  int          reads;
  int          t0;
  int          t1;
  int          n;
  bit          got;

  initial begin
    rst_i = 1'b1; start_i = 1'b0; chan_en_i = '0; base_addr_i = '0;
    rd_gnt_i = 1'b0; rd_rvalid_i = 1'b0; rd_rdata_i = '0; rd_err_i = 1'b0;
    a3 = '{64'h2000, 64'h2004, 64'h200C, 64'h2000, 64'h2004, 64'h2000, 64'h2004};
    d3 = '{32'h0, 32'h0, 32'h1, 32'h0, 32'h0, 32'h1, 32'h1};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req",   128'(rd_req_o), 128'(0));
    chk("rst_busy",  128'(busy_o), 128'(0));
    chk("rst_flags", 128'({eoc_o, pass_o, timeout_o, err_o}), 128'(0));
    chk("rst_done",  128'(done_o), 128'(0));
    chk("rst_code",  128'(exit_code_o), 128'(0));
    chk("rst_addr",  128'(rd_addr_o), 128'(0));
    rst_i = 1'b0;

    // 1: single channel, completes on the third read
    start_run(4'b0001, 64'h1000);
    chk("t1_busy", 128'(busy_o), 128'(1));
    serve("t1r0", 64'h1000, 32'h0, 1'b0, 0);
    serve("t1r1", 64'h1000, 32'h0, 1'b0, 0);
    serve("t1r2", 64'h1000, 32'h1, 1'b0, 0);
    wait_eoc("t1");
    chk("t1_done",  128'(done_o), 128'(4'b0001));
    chk("t1_code",  128'(exit_code_o), 128'(0));
    chk("t1_flags", 128'({pass_o, timeout_o, err_o, busy_o}), 128'(4'b1000));
    quiet(8, reqs);
    chk("t1_extra_reads", 128'(reqs), 128'(0));

    // 2: nonzero exit code fails the run
    start_run(4'b0001, 64'h1000);
    serve("t2r0", 64'h1000, 32'h0000_000B, 1'b0, 0);
    wait_eoc("t2");
    chk("t2_code",  128'(exit_code_o), 128'(5));
    chk("t2_done",  128'(done_o), 128'(4'b0001));
    chk("t2_flags", 128'({pass_o, timeout_o, err_o}), 128'(3'b000));

    // 3: sparse mask, round-robin skips disabled and finished channels
    start_run(4'b1011, 64'h2000);
    for (int i = 0; i < 7; i++) serve("t3", a3[i], d3[i], 1'b0, 0);
    wait_eoc("t3");
    chk("t3_done",  128'(done_o), 128'(4'b1011));
    chk("t3_code",  128'(exit_code_o), 128'(0));
    chk("t3_flags", 128'({pass_o, timeout_o, err_o}), 128'(3'b100));

    // 4: global timeout with slow grants
    start_run(4'b0001, 64'h3000);
    t0 = cyc;
    reads = 0;
    for (int k = 0; k < 12; k++) begin
      n = 0;
      while (rd_req_o !== 1'b1 && eoc_o !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      got = (rd_req_o === 1'b1);
      if (!got) break;
      serve("t4", 64'h3000, 32'h0, 1'b0, 3);
      reads++;
    end
    wait_eoc("t4");
    t1 = cyc;
    chk("t4_flags",   128'({timeout_o, pass_o, err_o}), 128'(3'b100));
    chk("t4_done",    128'(done_o), 128'(0));
    chk("t4_latency", 128'((t1 - t0) >= 45 && (t1 - t0) <= 60), 128'(1));
    chk("t4_reads",   128'(reads >= 5 && reads <= 7), 128'(1));

    // 5: bus error, with channel address wrapping past 2^64
    start_run(4'b0010, 64'hFFFF_FFFF_FFFF_FFFC);
    serve("t5r0", 64'h0, 32'h1, 1'b1, 0);
    wait_eoc("t5");
    chk("t5_flags", 128'({err_o, pass_o, timeout_o}), 128'(3'b100));
    chk("t5_done",  128'(done_o), 128'(0));
    chk("t5_code",  128'(exit_code_o), 128'(0));
    quiet(8, reqs);
    chk("t5_no_more_reads", 128'(reqs), 128'(0));

    // 6: reset while a response is outstanding, then an empty-mask start
    start_run(4'b0011, 64'h4000);
    serve("t6r0", 64'h4000, 32'h3, 1'b0, 0);
    n = 0;
    while (rd_req_o !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("t6_addr", 128'(rd_addr_o), 128'(64'h4004));
    rd_gnt_i = 1'b1;
    @(negedge clk);
    rd_gnt_i = 1'b0;
    chk("t6_pre_rst", 128'({busy_o, done_o}), 128'({1'b1, 4'b0001}));
    #1 rst_i = 1'b1;
    #1;
    chk("t6_rst_req_busy", 128'({rd_req_o, busy_o}), 128'(0));
    chk("t6_rst_flags", 128'({eoc_o, pass_o, timeout_o, err_o}), 128'(0));
    chk("t6_rst_done_code", 128'({done_o, exit_code_o}), 128'(0));
    @(negedge clk);
    rst_i = 1'b0;
    start_run(4'b0000, 64'h5000);
    chk("t6_empty_flags", 128'({eoc_o, pass_o, busy_o, timeout_o, err_o}), 128'(5'b11000));
    quiet(8, reqs);
    chk("t6_empty_reads", 128'(reqs), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cheshire_eoc_monitor.md
Name: cheshire_eoc_monitor

Overview:
Synthesizable multi-channel end-of-computation (EOC) monitor for Cheshire SoC test and bring-up. It polls one scratch word per enabled channel over a simple read request/response port. A channel is complete when bit 0 of its word is set; bits [CodeWidth:1] of that word hold the exit code. The block reports per-channel completion and exit codes, an overall pass/fail, a global timeout and bus errors. It sits beside the debug/scratch path, so regressions terminate without a host-side JTAG polling loop.

Parameters:
NumChannels, 4, number of monitored scratch words (1..32)
AddrWidth, 64, read address width
DataWidth, 32, read data width
CodeWidth, 31, exit-code bits per channel; must be <= DataWidth-1
ChanStride, 4, byte distance between consecutive channel words
PollInterval, 16, idle cycles before each read (0 means read back-to-back)
TimeoutCycles, 0, global cycle budget; 0 disables the timeout; 32-bit counter

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
start_i  in  1  start pulse; ignored while busy_o=1
chan_en_i  in  NumChannels  channel enable mask, sampled at start
base_addr_i  in  AddrWidth  address of channel 0, sampled at start
rd_req_o  out  1  read request
rd_addr_o  out  AddrWidth  base + idx*ChanStride
rd_gnt_i  in  1  request accepted
rd_rvalid_i  in  1  response valid (never in the grant cycle or earlier)
rd_rdata_i  in  DataWidth  response data
rd_err_i  in  1  response error, qualified by rd_rvalid_i
busy_o  out  1  monitoring in progress
eoc_o  out  1  sticky: run finished
pass_o  out  1  valid when eoc_o=1
timeout_o  out  1  sticky: budget exhausted
err_o  out  1  sticky: bus error seen
done_o  out  NumChannels  per-channel completion flags
exit_code_o  out  NumChannels*CodeWidth  per-channel codes; channel i at [i*CodeWidth +: CodeWidth]

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-high.
- Reset values: every output is 0; FSM is IDLE. Assertion mid-run drops rd_req_o immediately; no response is awaited afterwards.
- FSM states: IDLE, WAIT, REQ, RESP, DONE.
- IDLE, start_i=1, chan_en_i!=0:
  - latch chan_en_i and base_addr_i;
  - clear done_o, exit_code_o, timeout_o, err_o and the cycle counter;
  - idx = lowest enabled channel; load the interval counter with PollInterval; go to WAIT.
- IDLE, start_i=1, chan_en_i==0: go to DONE next cycle with pass_o=1.
- DONE: start_i=1 behaves exactly as in IDLE (restart).
- busy_o=1 in WAIT, REQ and RESP.
- WAIT: interval counter decrements each cycle; at 0, go to REQ. PollInterval=0 gives one WAIT cycle.
- REQ:
  - rd_req_o=1, rd_addr_o valid; both held stable until rd_gnt_i.
  - Address arithmetic is modulo 2^AddrWidth.
  - rd_req_o=1 and rd_gnt_i=1 in the same cycle: go to RESP.
  - At most one transaction outstanding.
- RESP, on rd_rvalid_i:
  - rd_err_i=1: set err_o; go to DONE.
  - else rd_rdata_i[0]=1: done_o[idx]=1; exit code of idx = rd_rdata_i[CodeWidth:1].
  - rd_rdata_i[0]=0: nothing recorded.
  - Then, if every enabled channel is done, go to DONE. Otherwise idx = next enabled, not-done channel after idx (round-robin, wrapping); reload the interval counter; go to WAIT.
- Timeout:
  - The cycle counter increments in WAIT, REQ and RESP, saturating at 2^32-1.
  - When it reaches TimeoutCycles (nonzero), set a pending flag.
  - Pending in WAIT: go to DONE next cycle.
  - Pending in REQ or RESP: the transaction completes first; its response is still recorded; then go to DONE.
  - timeout_o is set on DONE entry only if completion was not reached.
  - Completion and timeout in the same cycle: completion wins, timeout_o=0.
- DONE: eoc_o=1; busy_o=0.
- pass_o=1 iff:
  - no timeout and no error;
  - all enabled channels done;
  - all enabled exit codes are 0.
- Disabled channels keep done_o=0 and code 0.

Test Plan:
1. NumCh=1, PollInterval=2, rdata 0,0,1, gnt/rvalid immediate -> exactly 3 reads, done_o=1, code 0, eoc_o=1, pass_o=1.
2. Channel 0 returns 0x0000000B -> exit code 5, eoc_o=1, pass_o=0, timeout_o=0.
3. en=4'b1011, ch3 completes first, then ch0, then ch1 -> read order 0,1,3,0,1,0,1…, ch2 address never issued, done_o=4'b1011, pass_o=1.
4. TimeoutCycles=50, rdata always 0, rd_gnt_i delayed 3 cycles -> no req dropped before gnt, timeout_o=1, pass_o=0, eoc_o by cycle ~50+latency.
5. rd_err_i=1 on first response -> err_o=1, eoc_o=1, pass_o=0, no further requests.
6. Assert rst_i in RESP -> rd_req_o, busy_o and all flags 0 immediately. Then start with chan_en_i=0 -> eoc_o=1, pass_o=1, no request issued.
